// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage Y86-64 core: hazard stalls and bubbles,
// run/halt sequencing and saturating performance counters.
module pipe_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic [3:0]       m_stat,
   input  logic [3:0]       W_icode,
   input  logic [3:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             set_cc,
   output logic             cpu_halted,
   output logic [3:0]       halt_stat,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] mp_cnt,
   output logic [CNT_W-1:0] rb_cnt
);

   localparam logic [3:0] INop    = 4'h1;
   localparam logic [3:0] IMrmovq = 4'h5;
   localparam logic [3:0] IOpq    = 4'h6;
   localparam logic [3:0] IJxx    = 4'h7;
   localparam logic [3:0] IRet    = 4'h9;
   localparam logic [3:0] IPopq   = 4'hB;
   localparam logic [3:0] RNone   = 4'hF;
   localparam logic [3:0] SAok    = 4'h1;

   typedef enum logic [1:0] {StResetFlush, StRun, StHalted} state_e;

   state_e           state_q, state_d;
   logic [3:0]       halt_stat_q, halt_stat_d;
   logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, lu_q, lu_d, mp_q, mp_d, rb_q, rb_d;
   logic             lu, rt, mp, ex_m, ex_w, run_en;

   assign lu = (E_icode == IMrmovq || E_icode == IPopq) && (E_dstM != RNone) &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
   assign rt = (D_icode == IRet) || (E_icode == IRet) || (M_icode == IRet);
   assign mp = (E_icode == IJxx) && !e_Cnd;
   assign ex_m = (m_stat != SAok);
   assign ex_w = (W_stat != SAok);
   assign run_en = !rst && (state_q == StRun);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && v != '1) ? v + CNT_W'(1) : v;
   endfunction

   // Flush takes precedence over everything so a reset asserted mid-halt or
   // mid-stall immediately drains the pipe.
   always_comb begin
      F_stall    = 1'b0;
      D_stall    = 1'b0;
      D_bubble   = 1'b0;
      E_bubble   = 1'b0;
      M_bubble   = 1'b0;
      W_stall    = 1'b0;
      set_cc     = 1'b0;
      cpu_halted = 1'b0;
      if (rst || state_q == StResetFlush) begin
         D_bubble = 1'b1;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
      end else if (state_q == StHalted) begin
         F_stall    = 1'b1;
         D_stall    = 1'b1;
         W_stall    = 1'b1;
         E_bubble   = 1'b1;
         M_bubble   = 1'b1;
         cpu_halted = 1'b1;
      end else begin
         F_stall  = lu | rt;
         D_stall  = lu;
         D_bubble = mp | (rt & !lu);
         E_bubble = mp | lu;
         M_bubble = ex_m | ex_w;
         W_stall  = ex_w;
         set_cc   = (E_icode == IOpq) & !ex_m & !ex_w;
      end
   end

   always_comb begin
      state_d     = state_q;
      halt_stat_d = halt_stat_q;
      unique case (state_q)
         StResetFlush: state_d = StRun;
         StRun: begin
            if (ex_w) begin
               state_d     = StHalted;
               halt_stat_d = W_stat;
            end
         end
         StHalted: state_d = StHalted;
         default:  state_d = StResetFlush;
      endcase
      cyc_d = sat_inc(cyc_q, run_en);
      ret_d = sat_inc(ret_q, run_en && W_stat == SAok && W_icode != INop);
      lu_d  = sat_inc(lu_q, run_en && lu);
      mp_d  = sat_inc(mp_q, run_en && mp);
      rb_d  = sat_inc(rb_q, run_en && rt && !lu && !mp);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StResetFlush;
         halt_stat_q <= SAok;
         cyc_q       <= '0;
         ret_q       <= '0;
         lu_q        <= '0;
         mp_q        <= '0;
         rb_q        <= '0;
      end else begin
         state_q     <= state_d;
         halt_stat_q <= halt_stat_d;
         cyc_q       <= cyc_d;
         ret_q       <= ret_d;
         lu_q        <= lu_d;
         mp_q        <= mp_d;
         rb_q        <= rb_d;
      end
   end

   assign halt_stat = halt_stat_q;
   assign cyc_cnt   = cyc_q;
   assign ret_cnt   = ret_q;
   assign lu_cnt    = lu_q;
   assign mp_cnt    = mp_q;
   assign rb_cnt    = rb_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a 32-bit counter instance and a 4-bit one
// driven by the same stimulus so saturation can be observed.
module tb_pipe_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_icode, W_stat;
   logic       e_Cnd;

   logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, cpu_halted;
   logic [3:0]  halt_stat;
   logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rb_cnt;

   logic        s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall;
   logic        s_set_cc, s_cpu_halted;
   logic [3:0]  s_halt_stat;
   logic [3:0]  s_cyc_cnt, s_ret_cnt, s_lu_cnt, s_mp_cnt, s_rb_cnt;

   int total = 0;
   int bad   = 0;

   pipe_ctrl #(.CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
      .W_icode(W_icode), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
      .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
      .set_cc(set_cc), .cpu_halted(cpu_halted), .halt_stat(halt_stat), .cyc_cnt(cyc_cnt),
      .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .rb_cnt(rb_cnt)
   );

   pipe_ctrl #(.CNT_W(4)) u_dut_sat (
      .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
      .W_icode(W_icode), .W_stat(W_stat), .F_stall(s_F_stall), .D_stall(s_D_stall),
      .D_bubble(s_D_bubble), .E_bubble(s_E_bubble), .M_bubble(s_M_bubble),
      .W_stall(s_W_stall), .set_cc(s_set_cc), .cpu_halted(s_cpu_halted),
      .halt_stat(s_halt_stat), .cyc_cnt(s_cyc_cnt), .ret_cnt(s_ret_cnt), .lu_cnt(s_lu_cnt),
      .mp_cnt(s_mp_cnt), .rb_cnt(s_rb_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
      E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b1;
      M_icode = 4'h1; m_stat = 4'h1;
      W_icode = 4'h1; W_stat = 4'h1;
   endtask

   // Packed {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, cpu_halted}
   function automatic logic [7:0] ctl();
      return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, cpu_halted};
   endfunction

   initial begin
      idle();
      rst = 1'b1;
      settle();
      chk("rst_ctl", {24'd0, ctl()}, 32'h0000_0038);
      tick();
      tick();
      rst = 1'b0;
      settle();
      chk("flush_ctl", {24'd0, ctl()}, 32'h0000_0038);
      chk("flush_cyc", cyc_cnt, 32'd0);
      chk("flush_halt_stat", {28'd0, halt_stat}, 32'd1);
      tick();
      settle();
      chk("run_idle_ctl", {24'd0, ctl()}, 32'h0000_0000);
      chk("run_cyc0", cyc_cnt, 32'd0);
      chk("run_lu0", lu_cnt, 32'd0);
      tick();                                                // cyc 1

      // load/use on srcA
      E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
      settle();
      chk("lu_ctl", {24'd0, ctl()}, 32'h0000_00D0);
      tick();                                                // cyc 2, lu 1
      d_srcA = 4'h4; d_srcB = 4'hF;
      settle();
      chk("lu_cnt1", lu_cnt, 32'd1);
      chk("nolu_ctl", {24'd0, ctl()}, 32'h0000_0000);
      tick();                                                // cyc 3
      E_dstM = 4'hF; d_srcA = 4'hF;
      settle();
      chk("dstm_none_ctl", {24'd0, ctl()}, 32'h0000_0000);
      tick();                                                // cyc 4

      // mispredict
      idle();
      E_icode = 4'h7; e_Cnd = 1'b0;
      settle();
      chk("mp_ctl", {24'd0, ctl()}, 32'h0000_0030);
      tick();                                                // cyc 5, mp 1
      e_Cnd = 1'b1;
      settle();
      chk("taken_ctl", {24'd0, ctl()}, 32'h0000_0000);
      chk("mp_cnt1", mp_cnt, 32'd1);
      tick();                                                // cyc 6

      // ret in D for three cycles
      idle();
      D_icode = 4'h9;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("ret_ctl", {24'd0, ctl()}, 32'h0000_00A0);
         tick();                                             // cyc 7..9, rb 1..3
      end
      settle();
      chk("rb_cnt3", rb_cnt, 32'd3);

      // ret in D together with load/use: stall wins over bubble
      E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2;
      settle();
      chk("ret_lu_ctl", {24'd0, ctl()}, 32'h0000_00D0);
      tick();                                                // cyc 10, lu 2
      idle();
      settle();
      chk("lu_cnt2", lu_cnt, 32'd2);
      chk("rb_cnt_hold", rb_cnt, 32'd3);

      // two retiring OPq, with OPq in E enabling CC
      E_icode = 4'h6; W_icode = 4'h6;
      settle();
      chk("setcc_ctl", {24'd0, ctl()}, 32'h0000_0002);
      tick();
      tick();                                                // cyc 12, ret 2
      idle();
      settle();
      chk("ret_cnt2", ret_cnt, 32'd2);
      chk("cyc12", cyc_cnt, 32'd12);
      for (int i = 0; i < 6; i++) tick();                    // cyc 18

      // exception drain: fault in M, then in W, then halt
      E_icode = 4'h6; m_stat = 4'h3;
      settle();
      chk("exm_ctl", {24'd0, ctl()}, 32'h0000_0008);
      tick();                                                // cyc 19
      idle();
      W_icode = 4'h6; W_stat = 4'h3;
      settle();
      chk("exw_ctl", {24'd0, ctl()}, 32'h0000_000C);
      tick();                                                // cyc 20, now HALTED
      D_icode = 4'h9; E_icode = 4'h7; e_Cnd = 1'b0; W_icode = 4'h6; W_stat = 4'h1;
      settle();
      chk("halt_ctl", {24'd0, ctl()}, 32'h0000_00DD);
      chk("halt_stat", {28'd0, halt_stat}, 32'd3);
      for (int i = 0; i < 10; i++) tick();
      settle();
      chk("halt_cyc", cyc_cnt, 32'd20);
      chk("halt_ret", ret_cnt, 32'd2);
      chk("halt_lu", lu_cnt, 32'd2);
      chk("halt_mp", mp_cnt, 32'd1);
      chk("halt_rb", rb_cnt, 32'd3);
      chk("halt_stat_hold", {28'd0, halt_stat}, 32'd3);
      chk("sat_cyc", {28'd0, s_cyc_cnt}, 32'd15);
      chk("sat_ret", {28'd0, s_ret_cnt}, 32'd2);
      chk("sat_halted", {31'd0, s_cpu_halted}, 32'd1);

      // reset while halted
      rst = 1'b1;
      settle();
      chk("rst_in_halt_ctl", {24'd0, ctl()}, 32'h0000_0038);
      tick();
      rst = 1'b0;
      idle();
      settle();
      chk("post_rst_ctl", {24'd0, ctl()}, 32'h0000_0038);
      chk("post_rst_cyc", cyc_cnt, 32'd0);
      chk("post_rst_lu", lu_cnt, 32'd0);
      chk("post_rst_halt_stat", {28'd0, halt_stat}, 32'd1);
      chk("post_rst_sat_cyc", {28'd0, s_cyc_cnt}, 32'd0);
      tick();
      settle();
      chk("rerun_ctl", {24'd0, ctl()}, 32'h0000_0000);
      tick();
      settle();
      chk("rerun_cyc1", cyc_cnt, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the five-stage Y86-64 core. It computes stall and bubble requests for the F, D, E, M and W pipeline registers from hazard conditions: load/use, ret, branch mispredict and exception drain. A run/halt state machine freezes the pipe once a non-AOK status retires. Saturating performance counters track cycles, retired instructions, load/use stalls, mispredicts and ret bubbles.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
D_icode  in  4  icode in D register
d_srcA  in  4  decode-stage srcA (4'hF = none)
d_srcB  in  4  decode-stage srcB (4'hF = none)
E_icode  in  4  icode in E register
E_dstM  in  4  E register dstM (4'hF = none)
e_Cnd  in  1  execute-stage condition result
M_icode  in  4  icode in M register
m_stat  in  4  memory-stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
W_icode  in  4  icode in W register
W_stat  in  4  W register status
F_stall  out  1  hold F (PC) register
D_stall  out  1  hold D register
D_bubble  out  1  load nop into D
E_bubble  out  1  load nop into E
M_bubble  out  1  load nop into M
W_stall  out  1  hold W register
set_cc  out  1  enable CC update
cpu_halted  out  1  state == HALTED
halt_stat  out  4  W_stat captured at halt
cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rb_cnt  out  CNT_W each  cycles, retired, load/use stalls, mispredicts, ret bubbles

Behaviour:
- Icodes: HALT 0, NOP 1, JXX 7, RET 9, MRMOVQ 5, POPQ B, OPQ 6. A status is exceptional when it is not 1.
- Hazard terms are combinational from the inputs in the same cycle (zero latency):
  - lu = E_icode in {5,B} && E_dstM != F && (E_dstM == d_srcA || E_dstM == d_srcB)
  - rt = 9 in {D_icode, E_icode, M_icode}
  - mp = E_icode == 7 && !e_Cnd
  - ex_m = m_stat exceptional
  - ex_w = W_stat exceptional
- RUN outputs:
  - F_stall = lu | rt
  - D_stall = lu
  - D_bubble = mp | (rt & !lu)
  - E_bubble = mp | lu
  - M_bubble = ex_m | ex_w
  - W_stall = ex_w
  - set_cc = E_icode == 6 & !ex_m & !ex_w
- Priority: D_stall overrides D_bubble, so lu and rt together give F stall, D stall, E bubble, D_bubble=0. lu and mp are mutually exclusive by E_icode; if both inputs are forced true anyway, D_bubble=1 and D_stall=1, and the D register honours the stall.
- FSM states: RESET_FLUSH, RUN, HALTED.
  - rst=1 → RESET_FLUSH next cycle. While rst=1 or in RESET_FLUSH, outputs are D_bubble=E_bubble=M_bubble=1, all stalls 0, set_cc 0, cpu_halted 0.
  - RESET_FLUSH → RUN after 1 cycle with rst=0.
  - RUN → HALTED when ex_w is 1 at a clock edge. halt_stat <= W_stat on that edge.
  - HALTED is terminal until rst. Outputs: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0, cpu_halted=1.
  - rst mid-HALTED or mid-stall → RESET_FLUSH on the next edge. Counters and halt_stat clear.
- Reset values (registered on the rst edge): state RESET_FLUSH, halt_stat 4'h1, all counters 0.
- Counters update only in RUN. Each saturates at all-ones (no wrap).
  - cyc_cnt: +1 every RUN cycle
  - ret_cnt: +1 when W_stat==1 and W_icode != 1
  - lu_cnt: +1 when lu
  - mp_cnt: +1 when mp
  - rb_cnt: +1 when rt & !lu & !mp
- The cycle that transitions RUN→HALTED still counts in cyc_cnt. That cycle's W instruction (HALT or fault) is not counted as retired.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 → RESET_FLUSH outputs bubbles for 1 cycle, then RUN with all counters 0 and halt_stat=1.
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt +1. Repeat with d_srcA=4, d_srcB=F → all 0.
- Mispredict: E_icode=7, e_Cnd=0 → D_bubble=1, E_bubble=1, F_stall=0; mp_cnt +1. With e_Cnd=1 → no control outputs.
- Ret: D_icode=9 for 3 cycles with no lu → F_stall=1, D_bubble=1 each cycle, rb_cnt=3. Combined ret in D + lu → D_stall=1, D_bubble=0.
- Exception drain: m_stat=3 with E_icode=6 → M_bubble=1, set_cc=0. Next cycle W_stat=3 → W_stall=1; following cycle cpu_halted=1 and halt_stat=3, counters frozen for 10 cycles.
- Saturation/reset-in-halt: CNT_W=4, run 20 cycles → cyc_cnt=15. Assert rst in HALTED → next cycle RESET_FLUSH, cpu_halted=0, counters 0.
